// File: rtl/lcd_pkg.sv
// +----------------------------------------------------------------------------+
// | lcd_pkg: state encoding, command layout and reset timing defaults for the  |
// | LCD power-on initialisation sequencer.                                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package lcd_pkg;

  typedef logic [2:0] state_t;

  localparam state_t c_st_idle       = 3'd0;
  localparam state_t c_st_hwrst_low  = 3'd1;
  localparam state_t c_st_hwrst_wait = 3'd2;
  localparam state_t c_st_issue      = 3'd3;
  localparam state_t c_st_wait_dly   = 3'd4;
  localparam state_t c_st_finish     = 3'd5;

  // Command word: {dc, byte}; dc=0 selects command, dc=1 selects parameter data.
  localparam int c_cmd_w      = 9;
  localparam int c_cmd_dc_bit = 8;

  typedef logic [c_cmd_w-1:0] cmd_t;

  localparam int c_rst_low_cycles_def  = 270000;
  localparam int c_rst_wait_cycles_def = 3240000;

endpackage

`default_nettype wire

// File: rtl/delay_ctr.sv
// +----------------------------------------------------------------------------+
// | delay_ctr: loadable down-counter; expired is high while the count is zero. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module delay_ctr #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             count,
  output logic             expired
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (count && (r_cnt != '0)) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign expired = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/lcd_init_seq.sv
// +----------------------------------------------------------------------------+
// | lcd_init_seq: walks a command/delay table and streams it to the LCD        |
// | serializer; optional panel hardware reset under LCD_INIT_SEQ_HWRESET_EN.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module lcd_init_seq
  import lcd_pkg::*;
#(
  parameter int CTR_WIDTH       = 24,
  parameter int NUM_STEPS       = 16,
  parameter int RST_LOW_CYCLES  = c_rst_low_cycles_def,
  parameter int RST_WAIT_CYCLES = c_rst_wait_cycles_def,
  localparam int AW             = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [AW-1:0]        step_addr,
  input  logic [c_cmd_w-1:0]   step_cmd,
  input  logic [CTR_WIDTH-1:0] step_delay,
  input  logic                 step_last,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [c_cmd_w-1:0]   cmd_data,
  output logic                 lcd_rst_n
);

  localparam logic [AW-1:0] c_last_addr = AW'(NUM_STEPS - 1);

  // Counter loads N-1 so that the state holding the wait lasts exactly N cycles.
  localparam logic [CTR_WIDTH-1:0] c_rst_low_load  =
    (RST_LOW_CYCLES > 0) ? CTR_WIDTH'(RST_LOW_CYCLES - 1) : '0;
  localparam logic [CTR_WIDTH-1:0] c_rst_wait_load =
    (RST_WAIT_CYCLES > 0) ? CTR_WIDTH'(RST_WAIT_CYCLES - 1) : '0;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [AW-1:0]        r_addr;
  logic                 r_last;
  logic                 w_end;
  logic                 w_is_issue;
  logic                 w_accept;
  logic                 w_ctr_load;
  logic [CTR_WIDTH-1:0] w_ctr_val;
  logic                 w_ctr_count;
  logic                 w_expired;
  logic                 w_addr_clr;
  logic                 w_addr_inc;

  // The table's final slot terminates the run even when step_last is never set.
  assign w_end      = step_last || (r_addr == c_last_addr);
  assign w_is_issue = (r_state == c_st_issue);
  assign w_accept   = w_is_issue && cmd_ready;
  assign step_addr  = r_addr;

  delay_ctr #(
    .WIDTH(CTR_WIDTH)
  ) u_delay_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (w_ctr_load),
    .load_val (w_ctr_val),
    .count    (w_ctr_count),
    .expired  (w_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        if (start) begin
`ifdef LCD_INIT_SEQ_HWRESET_EN
          w_state_nxt = c_st_hwrst_low;
`else
          w_state_nxt = c_st_issue;
`endif
        end
      end
`ifdef LCD_INIT_SEQ_HWRESET_EN
      c_st_hwrst_low: begin
        if (w_expired) w_state_nxt = c_st_hwrst_wait;
      end
      c_st_hwrst_wait: begin
        if (w_expired) w_state_nxt = c_st_issue;
      end
`endif
      c_st_issue: begin
        if (cmd_ready) begin
          if (step_delay != '0) begin
            w_state_nxt = c_st_wait_dly;
          end else if (w_end) begin
            w_state_nxt = c_st_finish;
          end
        end
      end
      c_st_wait_dly: begin
        if (w_expired) w_state_nxt = r_last ? c_st_finish : c_st_issue;
      end
      c_st_finish: begin
        w_state_nxt = c_st_idle;
      end
      default: begin
        w_state_nxt = c_st_idle;
      end
    endcase
  end

  always_comb begin
    busy        = (r_state != c_st_idle);
    done        = (r_state == c_st_finish);
    cmd_valid   = w_is_issue;
    cmd_data    = w_is_issue ? step_cmd : '0;
    w_ctr_load  = 1'b0;
    w_ctr_val   = '0;
    w_ctr_count = 1'b0;
    w_addr_clr  = 1'b0;
    w_addr_inc  = 1'b0;
`ifdef LCD_INIT_SEQ_HWRESET_EN
    lcd_rst_n   = (r_state != c_st_hwrst_low);
`else
    lcd_rst_n   = 1'b1;
`endif
    case (r_state)
      c_st_idle: begin
        if (start) begin
          w_addr_clr = 1'b1;
          w_ctr_load = 1'b1;
          w_ctr_val  = c_rst_low_load;
        end
      end
      c_st_hwrst_low: begin
        w_ctr_count = 1'b1;
        if (w_expired) begin
          w_ctr_load = 1'b1;
          w_ctr_val  = c_rst_wait_load;
        end
      end
      c_st_hwrst_wait: begin
        w_ctr_count = 1'b1;
      end
      c_st_issue: begin
        if (cmd_ready) begin
          if (step_delay != '0) begin
            w_ctr_load = 1'b1;
            w_ctr_val  = step_delay - CTR_WIDTH'(1);
          end else if (!w_end) begin
            w_addr_inc = 1'b1;
          end
        end
      end
      c_st_wait_dly: begin
        w_ctr_count = 1'b1;
        if (w_expired && !r_last) w_addr_inc = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // step_last is only valid while its entry is addressed, so capture it on accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr <= '0;
      r_last <= 1'b0;
    end else begin
      if (w_addr_clr) begin
        r_addr <= '0;
      end else if (w_addr_inc) begin
        r_addr <= r_addr + AW'(1);
      end
      if (w_accept) r_last <= w_end;
    end
  end

endmodule

`default_nettype wire
